// File: rtl/gates_sweep_ctrl.sv
// Self-running sweep sequencer for the two-input gates datapath: applies (A,B) in
// Gray order 00,01,11,10, waits a programmable settle time, and captures each result.
`timescale 1ns/1ps

module gates_sweep_ctrl #(
    parameter int SETTLE_CYCLES = 2,
    parameter int Z_W           = 8
) (
    input  logic           clk_in,
    input  logic           rst_n_in,
    input  logic           start_in,
    input  logic           abort_in,
    input  logic [Z_W-1:0] z_in,
    output logic           a_out,
    output logic           b_out,
    output logic           busy_out,
    output logic           done_out,
    output logic [1:0]     step_out,
    output logic [3:0]     valid_out,
    input  logic [1:0]     rd_idx_in,
    output logic [Z_W-1:0] rd_data_out
);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_SETTLE,
        ST_CAPTURE,
        ST_DONE
    } state_t;

    localparam logic [7:0] SETTLE_LAST = 8'(SETTLE_CYCLES - 1);
    localparam logic [1:0] LAST_STEP   = 2'd3;

    state_t         r_state;
    logic [7:0]     r_cnt;
    logic [1:0]     r_step;
    logic           r_a;
    logic           r_b;
    logic [3:0]     r_valid;
    logic [Z_W-1:0] r_result [4];

    state_t         w_state_nxt;
    logic [7:0]     w_cnt_nxt;
    logic [1:0]     w_step_nxt;
    logic           w_a_nxt;
    logic           w_b_nxt;
    logic [3:0]     w_valid_nxt;
    logic           w_cap_en;
    logic [1:0]     w_step_inc;

    // Gray-coded vector {A,B} for a step: 0->00, 1->01, 2->11, 3->10.
    function automatic logic [1:0] gray_vec(input logic [1:0] step);
        return {step[1], step[1] ^ step[0]};
    endfunction

    assign w_step_inc = r_step + 2'd1;

    always_comb begin
        // NOTE: every next-state signal gets a hold default first so no path leaves
        // one unassigned, which would otherwise infer a latch.
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_step_nxt  = r_step;
        w_a_nxt     = r_a;
        w_b_nxt     = r_b;
        w_valid_nxt = r_valid;
        w_cap_en    = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (start_in) begin
                    {w_a_nxt, w_b_nxt} = gray_vec(2'd0);
                    w_step_nxt         = 2'd0;
                    w_cnt_nxt          = 8'd0;
                    w_valid_nxt        = 4'b0000;
                    w_state_nxt        = ST_SETTLE;
                end
            end

            ST_SETTLE: begin
                if (abort_in) begin
                    {w_a_nxt, w_b_nxt} = 2'b00;
                    w_step_nxt         = 2'd0;
                    w_state_nxt        = ST_IDLE;
                end else begin
                    w_cnt_nxt = r_cnt + 8'd1;
                    if (r_cnt == SETTLE_LAST) begin
                        w_state_nxt = ST_CAPTURE;
                    end
                end
            end

            ST_CAPTURE: begin
                // Abort wins over the capture: the pending step is neither stored nor marked.
                if (abort_in) begin
                    {w_a_nxt, w_b_nxt} = 2'b00;
                    w_step_nxt         = 2'd0;
                    w_state_nxt        = ST_IDLE;
                end else begin
                    w_cap_en              = 1'b1;
                    w_valid_nxt[r_step]   = 1'b1;
                    if (r_step == LAST_STEP) begin
                        {w_a_nxt, w_b_nxt} = 2'b00;
                        w_state_nxt        = ST_DONE;
                    end else begin
                        w_step_nxt         = w_step_inc;
                        {w_a_nxt, w_b_nxt} = gray_vec(w_step_inc);
                        w_cnt_nxt          = 8'd0;
                        w_state_nxt        = ST_SETTLE;
                    end
                end
            end

            ST_DONE: begin
                w_state_nxt = ST_IDLE;
            end

            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples the pre-edge values regardless of process ordering.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            r_cnt   <= 8'd0;
            r_step  <= 2'd0;
            r_a     <= 1'b0;
            r_b     <= 1'b0;
            r_valid <= 4'b0000;
        end else begin
            r_cnt   <= w_cnt_nxt;
            r_step  <= w_step_nxt;
            r_a     <= w_a_nxt;
            r_b     <= w_b_nxt;
            r_valid <= w_valid_nxt;
        end
    end

    // NOTE: the result bank is reset on purpose: a reset must wipe results from any
    // earlier sweep, so this is a small register file rather than a RAM.
    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            for (int k = 0; k < 4; k++) begin
                r_result[k] <= '0;
            end
        end else if (w_cap_en) begin
            r_result[r_step] <= z_in;
        end
    end

    assign a_out       = r_a;
    assign b_out       = r_b;
    assign busy_out    = (r_state == ST_SETTLE) || (r_state == ST_CAPTURE);
    assign done_out    = (r_state == ST_DONE);
    assign step_out    = r_step;
    assign valid_out   = r_valid;
    assign rd_data_out = r_result[rd_idx_in];

endmodule
